// File: rtl/gc_stream_packer.sv
// gc_stream_packer: turns GarbledCircuit's tagged per-cycle bus into typed records, buffers them
// in a 2-write/1-read FWFT FIFO and streams them out. Define GC_PACK_CNT_EN for rec/drop counters.
module gc_stream_packer #(
  parameter int unsigned S     = 16,
  parameter int unsigned K     = 128,
  parameter int unsigned CC    = 1,
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   tag,
  input  logic [S-1:0] cid,
  input  logic [S-1:0] index0,
  input  logic [S-1:0] index1,
  input  logic [K-1:0] data0,
  input  logic [K-1:0] data1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_type,
  output logic [S-1:0] out_cid,
  output logic [S-1:0] out_index,
  output logic [K-1:0] out_data,
`ifdef GC_PACK_CNT_EN
  output logic [31:0]  rec_count,
  output logic [31:0]  drop_count,
`endif
  output logic         overflow,
  output logic         done
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 2 + 2 * S + K;

  typedef logic [RW-1:0] rec_t;

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  rec_t        st0_q, st1_q;
  logic        st_v0_q, st_v1_q;
  logic        ended_q, overflow_q;

  rec_t          rec_a, rec_b;
  logic          va, vb, is_end, load;
  logic          empty, full, pop, wr0, wr1, drop;
  logic [AW:0]   used;
  logic [AW+1:0] free;
  logic [AW-1:0] wa0, wa1;
  rec_t          head;

  always_comb begin
    rec_a = {2'd0, cid, index0, data0};
    rec_b = {2'd0, cid, index1, data1};
    va    = 1'b0;
    vb    = 1'b0;
    if (tag[2]) begin
      va = tag[0];
      vb = tag[1];
    end else begin
      case (tag[1:0])
        2'b01: begin
          rec_a = {2'd1, cid, S'(0), data0};
          rec_b = {2'd1, cid, S'(1), data1};
          va    = 1'b1;
          vb    = 1'b1;
        end
        2'b10: begin
          rec_a = {2'd2, cid, index0, data0};
          rec_b = {2'd2, cid, index1, data1};
          va    = 1'b1;
          vb    = 1'b1;
        end
        2'b11: begin
          rec_a = {2'd3, cid, S'(0), data0};
          va    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign is_end = (cid == S'(CC));
  assign load   = !ended_q && !is_end;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign used  = wr_ptr_q - rd_ptr_q;
  // Slots freed by this cycle's pop are usable by this cycle's writes.
  assign free  = (full ? '0 : ((AW+2)'(DEPTH) - {1'b0, used})) + (AW+2)'(pop);
  assign wr0   = st_v0_q && (free != '0);
  assign wr1   = st_v1_q && (free >= (AW+2)'(2));
  assign drop  = (st_v0_q && !wr0) || (st_v1_q && !wr1);
  assign wa0   = wr_ptr_q[AW-1:0];
  assign wa1   = wr_ptr_q[AW-1:0] + AW'(1);

  // Stage holds the decoded records compacted so slot 1 is only valid when slot 0 is.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v0_q    <= 1'b0;
      st_v1_q    <= 1'b0;
      ended_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      st_v0_q    <= load && (va || vb);
      st_v1_q    <= load && va && vb;
      ended_q    <= ended_q || is_end;
      overflow_q <= overflow_q || drop;
      wr_ptr_q   <= wr_ptr_q + (AW+1)'(wr0) + (AW+1)'(wr1);
      rd_ptr_q   <= rd_ptr_q + (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    st0_q <= va ? rec_a : rec_b;
    st1_q <= rec_b;
    if (wr0) mem[wa0] <= st0_q;
    if (wr1) mem[wa1] <= st1_q;
  end

  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign out_valid = !empty;
  assign {out_type, out_cid, out_index, out_data} = empty ? '0 : head;
  assign overflow  = overflow_q;
  assign done      = ended_q && empty && !st_v0_q;

`ifdef GC_PACK_CNT_EN
  logic [31:0] rec_q, drop_q;
  logic [32:0] rec_sum, drop_sum;

  assign rec_sum  = {1'b0, rec_q} + 33'(wr0) + 33'(wr1);
  assign drop_sum = {1'b0, drop_q} + 33'(st_v0_q && !wr0) + 33'(st_v1_q && !wr1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q  <= '0;
      drop_q <= '0;
    end else begin
      rec_q  <= rec_sum[32] ? '1 : rec_sum[31:0];
      drop_q <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  assign rec_count  = rec_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_gc_stream_packer.sv
// Directed self-checking bench for gc_stream_packer (DEPTH=4, CC=1).
module tb_gc_stream_packer;
  localparam int unsigned S = 16, K = 128, CC = 1, DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   tag = '0;
  logic [S-1:0] cid = '0, index0 = '0, index1 = '0;
  logic [K-1:0] data0 = '0, data1 = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [1:0]   out_type;
  logic [S-1:0] out_cid, out_index;
  logic [K-1:0] out_data;
  logic         overflow, done;
`ifdef GC_PACK_CNT_EN
  logic [31:0]  rec_count, drop_count;
`endif

  int checks = 0;
  int failures = 0;

  gc_stream_packer #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tag(tag), .cid(cid), .index0(index0), .index1(index1),
    .data0(data0), .data1(data1), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_cid(out_cid), .out_index(out_index), .out_data(out_data),
`ifdef GC_PACK_CNT_EN
    .rec_count(rec_count), .drop_count(drop_count),
`endif
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [S-1:0] c, input logic [S-1:0] i0,
                       input logic [S-1:0] i1, input logic [K-1:0] d0, input logic [K-1:0] d1);
    tag = t; cid = c; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
    step();
    tag = 3'b000; cid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tag = '0; cid = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || out_type !== 2'd0 || out_cid !== '0 || out_index !== '0 ||
        out_data !== '0 || overflow !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: v=%b t=%0d c=%0d i=%0d d=%h ovf=%b done=%b want all zero",
               out_valid, out_type, out_cid, out_index, out_data, overflow, done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_labels();
    logic [1:0] et[2]; logic [S-1:0] ei[2]; logic [K-1:0] ed[2];
    et[0] = 2'd0; ei[0] = 16'd0; ed[0] = {4{32'hAAAA_AAAA}};
    et[1] = 2'd0; ei[1] = 16'd1; ed[1] = {4{32'hBBBB_BBBB}};
    out_ready = 1'b1;
    drive(3'b111, 16'd0, 16'd0, 16'd1, ed[0], ed[1]);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL labels_latency: out_valid=%b want 0", out_valid);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== et[i] || out_index !== ei[i] || out_data !== ed[i]) begin
        failures++;
        $display("FAIL labels_beat%0d: v=%b t=%0d i=%0d d=%h want t=%0d i=%0d d=%h", i, out_valid,
                 out_type, out_index, out_data, et[i], ei[i], ed[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL labels_end: v=%b ovf=%b want 0 0", out_valid, overflow);
    end
    // Only B present: single record carrying index1/data1.
    drive(3'b110, 16'd0, 16'd8, 16'd9, {4{32'h1111_1111}}, {4{32'h2222_2222}});
    step();
    checks++;
    if (out_valid !== 1'b1 || out_type !== 2'd0 || out_index !== 16'd9 ||
        out_data !== {4{32'h2222_2222}}) begin
      failures++;
      $display("FAIL labels_bonly: v=%b t=%0d i=%0d d=%h want 1 0 9 2222..", out_valid, out_type,
               out_index, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL labels_bonly_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_key_mask();
    logic [1:0] et[3]; logic [S-1:0] ei[3]; logic [K-1:0] ed[3];
    et[0] = 2'd1; ei[0] = 16'd0; ed[0] = {4{32'hC0C0_0001}};
    et[1] = 2'd1; ei[1] = 16'd1; ed[1] = {4{32'hC1C1_0002}};
    et[2] = 2'd3; ei[2] = 16'd0; ed[2] = {4{32'hDDDD_0003}};
    do_reset();
    drive(3'b001, 16'd0, 16'd5, 16'd7, ed[0], ed[1]);
    drive(3'b011, 16'd0, 16'd5, 16'd7, ed[2], {4{32'hDEAD_BEEF}});
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== et[i] || out_index !== ei[i] || out_data !== ed[i]) begin
        failures++;
        $display("FAIL keymask_beat%0d: v=%b t=%0d i=%0d d=%h want t=%0d i=%0d d=%h", i, out_valid,
                 out_type, out_index, out_data, et[i], ei[i], ed[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL keymask_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int j = 0; j < 3; j++)
      drive(3'b010, 16'd0, 16'(10 + 2 * j), 16'(11 + 2 * j), K'(100 + 2 * j), K'(101 + 2 * j));
    step();
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL bp_overflow: overflow=%b want 1", overflow);
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== 2'd2 || out_index !== 16'd10 || out_data !== K'(100)) begin
        failures++;
        $display("FAIL bp_stall%0d: v=%b t=%0d i=%0d d=%h want 1 2 10 %h", s, out_valid, out_type,
                 out_index, out_data, K'(100));
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== 2'd2 || out_index !== 16'(10 + i) ||
          out_data !== K'(100 + i)) begin
        failures++;
        $display("FAIL bp_beat%0d: v=%b t=%0d i=%0d d=%h want t=2 i=%0d", i, out_valid, out_type,
                 out_index, out_data, 10 + i);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL bp_drain: v=%b ovf=%b want 0 1", out_valid, overflow);
    end
`ifdef GC_PACK_CNT_EN
    checks++;
    if (rec_count !== 32'd4 || drop_count !== 32'd2) begin
      failures++; $display("FAIL bp_counts: rec=%0d drop=%0d want 4 2", rec_count, drop_count);
    end
`endif
  endtask

  task automatic test_partial();
    logic [1:0] et[4]; logic [S-1:0] ei[4];
    et[0] = 2'd2; ei[0] = 16'd1;
    et[1] = 2'd2; ei[1] = 16'd2;
    et[2] = 2'd0; ei[2] = 16'd3;
    et[3] = 2'd2; ei[3] = 16'd20;
    do_reset();
    drive(3'b010, 16'd0, 16'd1, 16'd2, K'(200), K'(201));
    drive(3'b101, 16'd0, 16'd3, 16'd4, K'(202), K'(999));
    step();
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL partial_pre: overflow=%b want 0", overflow);
    end
    drive(3'b010, 16'd0, 16'd20, 16'd21, K'(203), K'(204));
    step();
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL partial_ovf: overflow=%b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== et[i] || out_index !== ei[i] ||
          out_data !== K'(200 + i)) begin
        failures++;
        $display("FAIL partial_beat%0d: v=%b t=%0d i=%0d d=%0d want t=%0d i=%0d d=%0d", i,
                 out_valid, out_type, out_index, out_data, et[i], ei[i], 200 + i);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL partial_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_end();
    do_reset();
    drive(3'b010, 16'd0, 16'd30, 16'd31, K'(300), K'(301));
    drive(3'b010, 16'(CC), 16'd40, 16'd41, K'(400), K'(401));
    drive(3'b111, 16'd0, 16'd50, 16'd51, K'(500), K'(501));
    step();
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL end_pending: done=%b v=%b want 0 1", done, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== 2'd2 || out_index !== 16'(30 + i) ||
          out_cid !== 16'd0 || done !== 1'b0) begin
        failures++;
        $display("FAIL end_beat%0d: v=%b t=%0d i=%0d c=%0d done=%b want 1 2 %0d 0 0", i,
                 out_valid, out_type, out_index, out_cid, done, 30 + i);
      end
      step();
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1) begin
        failures++; $display("FAIL end_done%0d: v=%b done=%b want 0 1", s, out_valid, done);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(3'b010, 16'd0, 16'd60, 16'd61, K'(600), K'(601));
    drive(3'b101, 16'd0, 16'd62, 16'd63, K'(602), K'(603));
    step();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 16'd60) begin
      failures++; $display("FAIL rmid_pre: v=%b i=%0d want 1 60", out_valid, out_index);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL rmid_post: v=%b done=%b ovf=%b d=%h want 0 0 0 0", out_valid, done, overflow,
               out_data);
    end
    drive(3'b011, 16'd0, 16'd7, 16'd7, K'(777), K'(888));
    step();
    checks++;
    if (out_valid !== 1'b1 || out_type !== 2'd3 || out_index !== 16'd0 || out_data !== K'(777)) begin
      failures++;
      $display("FAIL rmid_fresh: v=%b t=%0d i=%0d d=%0d want 1 3 0 777", out_valid, out_type,
               out_index, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_labels();
    test_key_mask();
    test_backpressure();
    test_partial();
    test_end();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
